// File: rtl/sipo_deframer.sv
// rtl/sipo_deframer.sv - LSB-first serial-to-parallel word assembler with FWFT output queue
module sipo_deframer #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       serial_in,
   input  logic                       bit_valid,
   input  logic                       align,
   output logic [WIDTH-1:0]           word_out,
   output logic                       word_valid,
   input  logic                       word_ready,
   output logic [$clog2(DEPTH):0]     fill,
   output logic                       overflow,
   input  logic                       clear_ovf
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int FILL_W = PTR_W + 1;

   logic [CNT_W-1:0]  bit_cnt;
   logic [WIDTH-1:0]  asm_reg;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;

   logic              last_bit;
   logic              push;
   logic              pop;
   logic              full;
   logic              accept;
   logic              drop;
   logic [WIDTH-1:0]  new_word;

   assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
   assign push     = bit_valid && !align && last_bit;
   assign pop      = word_valid && word_ready;
   assign full     = (fill == FILL_W'(DEPTH));
   // A full queue still takes a word when the head leaves on the same edge.
   assign accept   = push && (!full || pop);
   assign drop     = push && full && !pop;
   assign new_word = {serial_in, asm_reg[WIDTH-2:0]};

   assign word_valid = (fill != '0);
   assign word_out   = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (!reset) begin
         bit_cnt  <= '0;
         asm_reg  <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fill     <= '0;
         overflow <= 1'b0;
      end else begin
         if (align) begin
            asm_reg <= bit_valid ? WIDTH'(serial_in) : '0;
            bit_cnt <= bit_valid ? CNT_W'(1) : '0;
         end else if (bit_valid) begin
            asm_reg[bit_cnt] <= serial_in;
            bit_cnt          <= last_bit ? '0 : bit_cnt + CNT_W'(1);
         end

         if (accept) begin
            mem[wr_ptr] <= new_word;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end

         if (accept && !pop) begin
            fill <= fill + FILL_W'(1);
         end else if (pop && !accept) begin
            fill <= fill - FILL_W'(1);
         end

         // A drop on the same edge as clear_ovf keeps the flag set.
         if (drop) begin
            overflow <= 1'b1;
         end else if (clear_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sipo_deframer.sv
// tb/tb_sipo_deframer.sv - directed scoreboard bench for sipo_deframer
module tb_sipo_deframer;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       serial_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       align = 1'b0;
   logic [3:0] word_out;
   logic       word_valid;
   logic       word_ready = 1'b0;
   logic [1:0] fill;
   logic       overflow;
   logic       clear_ovf = 1'b0;

   int         n_assert = 0;
   int         n_fail = 0;
   logic [3:0] sb [$];

   sipo_deframer #(.WIDTH(4), .DEPTH(2)) dut (
      .clock      (clock),
      .reset      (reset),
      .serial_in  (serial_in),
      .bit_valid  (bit_valid),
      .align      (align),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .fill       (fill),
      .overflow   (overflow),
      .clear_ovf  (clear_ovf)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, score any pop, return 1ns after the rising edge.
   task automatic cyc(input logic b, input logic v, input logic a, input logic r,
                      input logic c = 1'b0);
      logic       v0, r0, rst0;
      logic [3:0] w0;
      @(negedge clock);
      serial_in  = b;
      bit_valid  = v;
      align      = a;
      word_ready = r;
      clear_ovf  = c;
      v0 = word_valid;
      r0 = word_ready;
      w0 = word_out;
      rst0 = reset;
      if (rst0 && v0 && r0) begin
         if (sb.size() == 0) chk("unexpected_word", 32'(word_out), 32'hFFFF);
         else                chk("word_out", 32'(word_out), 32'(sb.pop_front()));
      end
      @(posedge clock);
      #1;
      if (rst0 && v0 && !r0) chk("stable", 32'(word_out), 32'(w0));
   endtask

   task automatic send_word(input logic [3:0] w, input logic exp_push,
                            input logic r_bits, input logic r_last);
      for (int i = 0; i < 4; i++) begin
         if (i == 3 && exp_push) sb.push_back(w);
         cyc(w[i], 1'b1, 1'b0, (i == 3) ? r_last : r_bits);
      end
   endtask

   initial begin
      // Reset state
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("rst_valid", 32'(word_valid), 0);
      chk("rst_fill", 32'(fill), 0);
      chk("rst_ovf", 32'(overflow), 0);
      reset = 1'b1;

      // Basic assembly: 1,0,1,1 -> 4'hD
      send_word(4'hD, 1'b1, 1'b1, 1'b1);
      chk("basic_valid", 32'(word_valid), 1);
      chk("basic_word", 32'(word_out), 32'hD);
      chk("basic_fill1", 32'(fill), 1);
      cyc(0, 0, 0, 1);
      chk("basic_valid0", 32'(word_valid), 0);
      chk("basic_fill0", 32'(fill), 0);
      chk("basic_ovf", 32'(overflow), 0);

      // Backpressure and overflow
      send_word(4'h1, 1'b1, 1'b0, 1'b0);
      chk("bp_fill1", 32'(fill), 1);
      send_word(4'h2, 1'b1, 1'b0, 1'b0);
      chk("bp_fill2", 32'(fill), 2);
      chk("bp_ovf_pre", 32'(overflow), 0);
      send_word(4'h3, 1'b0, 1'b0, 1'b0);
      chk("bp_ovf_set", 32'(overflow), 1);
      chk("bp_fill_full", 32'(fill), 2);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("bp_drained", 32'(word_valid), 0);
      chk("bp_ovf_sticky", 32'(overflow), 1);
      cyc(0, 0, 0, 0, 1);
      chk("bp_ovf_clear", 32'(overflow), 0);

      // Alignment: 1,1 discarded, then 0(align),1,0,1 -> 4'hA
      cyc(1, 1, 0, 1);
      cyc(1, 1, 0, 1);
      cyc(0, 1, 1, 1);
      chk("al_no_partial", 32'(word_valid), 0);
      cyc(1, 1, 0, 1);
      cyc(0, 1, 0, 1);
      chk("al_still_empty", 32'(word_valid), 0);
      sb.push_back(4'hA);
      cyc(1, 1, 0, 1);
      chk("al_word", 32'(word_out), 32'hA);
      cyc(0, 0, 0, 1);
      chk("al_one_word", 32'(fill), 0);

      // Push and pop on the same edge at full
      send_word(4'h5, 1'b1, 1'b0, 1'b0);
      send_word(4'h6, 1'b1, 1'b0, 1'b0);
      chk("pp_full", 32'(fill), 2);
      send_word(4'h7, 1'b1, 1'b0, 1'b1);
      chk("pp_fill", 32'(fill), 2);
      chk("pp_ovf", 32'(overflow), 0);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("pp_drained", 32'(fill), 0);

      // Gapped input with random consumer stalls
      for (int i = 0; i < 4; i++) begin
         logic [3:0] w9;
         w9 = 4'h9;
         repeat ($urandom_range(0, 3)) cyc(0, 0, 0, 1'($urandom_range(0, 1)));
         if (i == 3) sb.push_back(w9);
         cyc(w9[i], 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      end
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      for (int k = 0; k < 20 && sb.size() > 0; k++) cyc(0, 0, 0, 1);
      chk("gap_delivered", 32'(sb.size()), 0);
      cyc(0, 0, 0, 1);
      chk("gap_empty", 32'(word_valid), 0);

      // Reset mid-word
      cyc(1, 1, 0, 1);
      cyc(1, 1, 0, 1);
      reset = 1'b0;
      cyc(0, 0, 0, 1);
      chk("rmw_fill", 32'(fill), 0);
      chk("rmw_valid", 32'(word_valid), 0);
      reset = 1'b1;
      send_word(4'hF, 1'b1, 1'b1, 1'b1);
      chk("rmw_word", 32'(word_out), 32'hF);
      cyc(0, 0, 0, 1);
      chk("rmw_ovf", 32'(overflow), 0);
      chk("rmw_empty", 32'(word_valid), 0);
      chk("sb_empty", 32'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/sipo_deframer.md
# sipo_deframer

Serial-to-parallel receive stage: samples a bit-serial stream (LSB first, one bit per qualified clock), assembles WIDTH-bit words and buffers them in a small first-word-fall-through queue with a valid/ready output handshake. It sits directly downstream of the 4-bit PISO serializer, or at the far end of its serial link, and reconstructs the parallel words that the serializer emits. The queue absorbs short consumer stalls. Words that arrive while the queue is full are dropped and flagged.

## Interface
- WIDTH, 4, word width in bits; must be ≥ 2
- DEPTH, 2, output queue entries; power of two, ≥ 2
- clock  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- serial_in  in  1  serial data bit
- bit_valid  in  1  serial_in is sampled on this edge
- align  in  1  word-boundary restart; see Operation
- word_out  out  WIDTH  head-of-queue word
- word_valid  out  1  queue non-empty
- word_ready  in  1  consumer accepts word_out this edge
- fill  out  $clog2(DEPTH)+1  number of words queued
- overflow  out  1  sticky: a completed word was dropped
- clear_ovf  in  1  clears overflow

## Operation
- **Bit counter** bit_cnt runs from 0 to WIDTH-1. When bit_valid=1, serial_in is written to bit position bit_cnt of the assembly register and bit_cnt increments.
- **Word completion:** when bit_valid=1 and bit_cnt=WIDTH-1, the completed word {serial_in, asm[WIDTH-2:0]} is pushed to the queue and bit_cnt wraps to 0.
- **align=1 with bit_valid=1:** the partial word is discarded. serial_in becomes bit 0 of a new word and bit_cnt becomes 1. No push occurs.
- **align=1 with bit_valid=0:** the partial word is discarded and bit_cnt becomes 0.
- **Idle cycles** (bit_valid=0, align=0) leave all assembly state unchanged. Gaps are allowed anywhere in a word.
- **Pop:** occurs when word_valid=1 and word_ready=1. word_ready while empty is ignored.
- **Push when full:**
  - If a pop happens on the same edge, the push is accepted. fill is unchanged and order is preserved.
  - Otherwise the new word is dropped, the queue is unchanged, and overflow is set.
- **Simultaneous push and pop** on a non-full, non-empty queue leaves fill unchanged.
- **overflow:**
  - Stays at 1 until clear_ovf=1.
  - If a set and clear_ovf occur on the same edge, the set wins and overflow stays 1.
- **Stability:** word_out is stable while word_valid=1 and word_ready=0. word_out is don't-care while word_valid=0.
- **Pointers:** read and write pointers wrap modulo DEPTH.

## Timing
- **Reset** (reset=0 at an edge) dominates all other inputs and produces:
  - bit_cnt=0 and assembly register=0
  - queue empty, word_valid=0, fill=0
  - overflow=0
- Reset mid-word discards the partial word and all queued words.
- **Latency:** the last bit of a word sampled at edge N gives word_valid=1 and word_out=word from just after edge N, provided the queue was empty. That is one edge from last bit to visible word.
- **fill** updates on the same edge as the push or pop that changes it.
- All outputs are registered or derived from registered state. There are no combinational paths from any input to any output.
- **Throughput:** one bit per cycle sustained. A word completes at most every WIDTH cycles, and the queue drains one word per cycle.

## Test plan
- **Basic assembly:** reset; word_ready=1; bits 1,0,1,1 on consecutive cycles. Required: word_valid pulses for one cycle after the 4th bit with word_out=4'hD, fill goes 0→1→0, overflow=0.
- **Backpressure and overflow:** word_ready=0; stream words 4'h1, 4'h2, 4'h3. Required:
  - fill=2 after the 2nd word.
  - The 3rd word is dropped and overflow=1 on that edge.
  - Raising word_ready then yields 4'h1 then 4'h2, then word_valid=0.
  - clear_ovf=1 gives overflow=0.
- **Alignment:** send bits 1,1, then align=1 with bit_valid=1 and serial_in=0, then bits 1,0,1. Required: exactly one word, 4'hA; the partial 2'b11 never appears.
- **Push/pop at full:** fill=2 with head 4'h5 and second entry 4'h6; the 4th bit of 4'h7 arrives on the same edge as word_ready=1. Required: no overflow, fill stays 2, and the next words out are 4'h6 then 4'h7.
- **Gapped input:** bits of 4'h9 separated by 0-3 idle cycles each, with random word_ready. Required: 4'h9 is delivered once and word_out is held stable while stalled.
- **Reset mid-word:** send 2 bits, hold reset=0 for 1 cycle, then send bits of 4'hF. Required: only 4'hF is delivered; overflow=0, and fill=0 during reset.
